// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin merge of NUM_REQ packet sources onto one sync-FIFO
//            write port; each grant is capped at BURST_MAX beats.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int c_ID_W  = $clog2(NUM_REQ);
  localparam int c_CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_BURST_LAST = c_CNT_W'(BURST_MAX - 1);
  localparam logic [c_ID_W-1:0]  c_ID_RESET   = c_ID_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_beat_cnt;

  logic [DATA_WIDTH-1:0] w_data [NUM_REQ];
  logic [c_ID_W-1:0]     w_next_id;
  logic                  w_found;
  logic                  w_sel_valid;
  logic                  w_sel_last;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  function automatic logic [c_ID_W-1:0] rr_index(input logic [c_ID_W-1:0] base,
                                                 input int offset);
    return c_ID_W'((int'(base) + offset) % NUM_REQ);
  endfunction

  // Search starts one past the last grantee so every requester gets a turn.
  always_comb begin
    w_next_id = grant_id;
    w_found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && req_valid[rr_index(grant_id, k)]) begin
        w_found   = 1'b1;
        w_next_id = rr_index(grant_id, k);
      end
    end
  end

  assign busy        = (r_state == S_GRANT);
  assign w_sel_valid = req_valid[grant_id];
  assign w_sel_last  = req_last[grant_id];
  assign fifo_din    = w_data[grant_id];
  assign fifo_wr_en  = busy & ~fifo_full & w_sel_valid;

  always_comb begin
    req_ready = '0;
    if (busy && !fifo_full) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      grant_id   <= c_ID_RESET;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_GRANT;
            grant_id   <= w_next_id;
            r_beat_cnt <= '0;
          end
        end
        S_GRANT: begin
          // A stalled or idle grantee keeps the grant; only real writes advance it.
          if (fifo_wr_en) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_sel_last || (r_beat_cnt == c_BURST_LAST)) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Directed scoreboard bench for fifo_wr_arbiter (4 req, 16b, burst 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int c_NREQ = 4;
  localparam int c_DW   = 16;
  localparam int c_BMAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [15:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;
  logic [1:0]  grant_id;
  logic        busy;

  fifo_wr_arbiter #(
    .NUM_REQ   (c_NREQ),
    .DATA_WIDTH(c_DW),
    .BURST_MAX (c_BMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo_din  (fifo_din),
    .fifo_wr_en(fifo_wr_en),
    .fifo_full (fifo_full),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
    logic [7:0]  gap;   // cycles since previous write; 0 = not checked
  } exp_t;

  exp_t        exp_q[$];
  logic [16:0] src_q [c_NREQ][$];   // {last, data}
  logic [3:0]  hold = '0;
  logic [3:0]  acc  = '0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_count = 0;
  int          cyc      = 0;
  int          last_wr_cyc = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every write.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    acc = req_valid & req_ready;
    if (!rst) begin
      if (fifo_full) begin
        chk("no_write_when_full", int'(fifo_wr_en), 0);
        chk("ready_low_when_full", int'(req_ready), 0);
      end
      if (fifo_wr_en) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got id %0d data 0x%0h, expected no write",
                   grant_id, fifo_din);
        end else begin
          e = exp_q.pop_front();
          chk("wr_id", int'(grant_id), int'(e.id));
          chk("wr_data", int'(fifo_din), int'(e.data));
          if (e.gap != 0) chk("wr_gap", cyc - last_wr_cyc, int'(e.gap));
        end
        last_wr_cyc = cyc;
      end
    end
  end

  task automatic drive();
    logic [16:0] b;
    for (int i = 0; i < c_NREQ; i++) begin
      if (src_q[i].size() != 0) begin
        b = src_q[i][0];
        req_valid[i] = ~hold[i];
        req_data[i*c_DW +: c_DW] = b[15:0];
        req_last[i] = b[16];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*c_DW +: c_DW] = '0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < c_NREQ; i++) begin
      if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    end
    drive();
  endtask

  task automatic send(input int r, input logic [15:0] d, input logic last);
    src_q[r].push_back({last, d});
  endtask

  task automatic expect_wr(input int id, input logic [15:0] d, input int gap);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    e.gap  = 8'(gap);
    exp_q.push_back(e);
  endtask

  task automatic wait_writes(input int base, input int n, input string tag);
    int t = 0;
    while ((wr_count - base) < n && t < 200) begin
      cycle();
      t++;
    end
    if ((wr_count - base) < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d writes, expected %0d", tag, wr_count - base, n);
    end
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      cycle();
      t++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) cycle();
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ready"}, int'(req_ready), 0);
    chk({tag, "_wr_en"}, int'(fifo_wr_en), 0);
    chk({tag, "_grant_id"}, int'(grant_id), 3);
    for (int i = 0; i < c_NREQ; i++) src_q[i].delete();
    drive();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_wr_en", int'(fifo_wr_en), 0);
    chk("rst_grant_id", int'(grant_id), 3);
    rst = 1'b0;

    // Single requester, 3-beat packet, then an IDLE bubble.
    base = wr_count;
    send(0, 16'h0011, 1'b0); send(0, 16'h0022, 1'b0); send(0, 16'h0033, 1'b1);
    expect_wr(0, 16'h0011, 0); expect_wr(0, 16'h0022, 1); expect_wr(0, 16'h0033, 1);
    drive();
    wait_writes(base, 3, "single");
    #1;
    chk("bubble_busy", int'(busy), 0);
    chk("bubble_wr_en", int'(fifo_wr_en), 0);
    wait_drain("single");

    // Pointer back to 3 so requester 0 wins; all four valid, 2-beat packets.
    pulse_reset("rst2");
    send(0, 16'h0A00, 1'b0); send(0, 16'h0A01, 1'b1);
    send(0, 16'h0A02, 1'b0); send(0, 16'h0A03, 1'b1);
    send(1, 16'h0A10, 1'b0); send(1, 16'h0A11, 1'b1);
    send(2, 16'h0A20, 1'b0); send(2, 16'h0A21, 1'b1);
    send(3, 16'h0A30, 1'b0); send(3, 16'h0A31, 1'b1);
    expect_wr(0, 16'h0A00, 0); expect_wr(0, 16'h0A01, 1);
    expect_wr(1, 16'h0A10, 2); expect_wr(1, 16'h0A11, 1);
    expect_wr(2, 16'h0A20, 2); expect_wr(2, 16'h0A21, 1);
    expect_wr(3, 16'h0A30, 2); expect_wr(3, 16'h0A31, 1);
    expect_wr(0, 16'h0A02, 2); expect_wr(0, 16'h0A03, 1);
    drive();
    wait_drain("rr4");

    // Requester 2: 10 beats, last only on the 10th; splits 4/4/2 around 3 and 0.
    for (int b = 0; b < 10; b++) send(2, 16'h0C00 + 16'(b), (b == 9));
    send(3, 16'h0D30, 1'b1); send(3, 16'h0D31, 1'b1);
    send(0, 16'h0D00, 1'b1); send(0, 16'h0D01, 1'b1);
    for (int b = 0; b < 4; b++) expect_wr(2, 16'h0C00 + 16'(b), (b == 0) ? 0 : 1);
    expect_wr(3, 16'h0D30, 2);
    expect_wr(0, 16'h0D00, 2);
    for (int b = 4; b < 8; b++) expect_wr(2, 16'h0C00 + 16'(b), (b == 4) ? 2 : 1);
    expect_wr(3, 16'h0D31, 2);
    expect_wr(0, 16'h0D01, 2);
    expect_wr(2, 16'h0C08, 2); expect_wr(2, 16'h0C09, 1);
    drive();
    wait_drain("burst");

    // FIFO full for 3 cycles after the second beat of requester 3.
    base = wr_count;
    for (int b = 0; b < 4; b++) send(3, 16'h0E00 + 16'(b), (b == 3));
    expect_wr(3, 16'h0E00, 0); expect_wr(3, 16'h0E01, 1);
    expect_wr(3, 16'h0E02, 4); expect_wr(3, 16'h0E03, 1);
    drive();
    wait_writes(base, 2, "full");
    fifo_full = 1'b1;
    #1;
    chk("full_ready", int'(req_ready), 0);
    chk("full_wr_en", int'(fifo_wr_en), 0);
    repeat (3) cycle();
    fifo_full = 1'b0;
    wait_drain("full");

    // Grantee 0 drops valid for 2 cycles; requester 1 must wait.
    base = wr_count;
    for (int b = 0; b < 4; b++) send(0, 16'h0F00 + 16'(b), (b == 3));
    send(1, 16'h0F10, 1'b1);
    expect_wr(0, 16'h0F00, 0); expect_wr(0, 16'h0F01, 1);
    expect_wr(0, 16'h0F02, 3); expect_wr(0, 16'h0F03, 1);
    expect_wr(1, 16'h0F10, 2);
    drive();
    wait_writes(base, 2, "gap");
    hold = 4'b0001;
    drive();
    #1;
    chk("hold_grant_id", int'(grant_id), 0);
    chk("hold_busy", int'(busy), 1);
    chk("hold_ready", int'(req_ready), 4'b0001);
    chk("hold_wr_en", int'(fifo_wr_en), 0);
    cycle();
    cycle();
    hold = 4'b0000;
    drive();
    wait_drain("gap");

    // Reset during beat 2 of a 4-beat grant to requester 2.
    base = wr_count;
    for (int b = 0; b < 4; b++) send(2, 16'h0100 + 16'(b), (b == 3));
    expect_wr(2, 16'h0100, 0);
    drive();
    wait_writes(base, 1, "midrst");
    pulse_reset("rst6");
    chk("midrst_writes", wr_count - base, 1);
    chk("midrst_pending", exp_q.size(), 0);
    send(1, 16'h0110, 1'b1);
    send(0, 16'h0200, 1'b1);
    expect_wr(0, 16'h0200, 0);
    expect_wr(1, 16'h0110, 2);
    drive();
    wait_drain("postrst");

    chk("total_writes", wr_count, 39);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
